// File: rtl/atm_pkg.sv
// Shared types and default sizing for the ATM session controller slice.
package atm_pkg;

  localparam int unsigned BALANCE_WIDTH_DEF  = 20;
  localparam int unsigned MAX_TRIES_DEF      = 3;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    PSW_WAIT,
    CHECK_REQ,
    CHECK_WAIT,
    MENU,
    EXEC,
    COMMIT,
    EJECT
  } state_t;

  typedef enum logic [1:0] {
    OP_EXIT     = 2'b00,
    OP_INQUIRY  = 2'b01,
    OP_WITHDRAW = 2'b10,
    OP_DEPOSIT  = 2'b11
  } op_t;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Session controller <-> account database link.
interface atm_session_ctrl_if #(
  parameter int unsigned balance_width = atm_pkg::BALANCE_WIDTH_DEF
);
  logic                     card_in;
  logic                     op_done;
  logic [balance_width-1:0] updated_balance;
  logic                     wrong_psw;
  logic [balance_width-1:0] balance;

  modport master (
    output card_in, op_done, updated_balance,
    input  wrong_psw, balance
  );

  modport slave (
    input  card_in, op_done, updated_balance,
    output wrong_psw, balance
  );
endinterface

// File: rtl/session_timer.sv
// Inactivity down-counter: load holds it at the limit, expired flags zero.
module session_timer #(
  parameter int unsigned timeout_cycles = atm_pkg::TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int unsigned W = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(timeout_cycles);
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);
endmodule

// File: rtl/atm_session_ctrl.sv
// Customer-session FSM: card/PIN sequencing, menu operations, balance arithmetic.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned balance_width  = BALANCE_WIDTH_DEF,
  parameter int unsigned max_tries      = MAX_TRIES_DEF,
  parameter int unsigned timeout_cycles = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  atm_session_ctrl_if.master       db,
  input  logic                     card_inserted,
  input  logic                     psw_valid,
  input  logic                     op_valid,
  input  logic [1:0]               op_sel,
  input  logic [balance_width-1:0] amount,
  output logic [balance_width-1:0] balance_disp,
  output logic                     op_error,
  output logic                     card_eject,
  output logic                     card_retained
);
  localparam int unsigned BW = balance_width;
  localparam int unsigned TW = (max_tries > 1) ? $clog2(max_tries) : 1;

  state_t        state;
  op_t           op_r;
  logic          card_q;
  logic [TW-1:0] tries;
  logic [BW-1:0] held;
  logic [BW-1:0] new_bal;
  logic [BW-1:0] amt_r;
  logic          card_in_q;
  logic          op_done_q;
  logic          timer_en;
  logic          timer_load;
  logic          timer_expired;
  logic [BW:0]   sum;
  logic [BW-1:0] diff;

  assign db.card_in         = card_in_q;
  assign db.op_done         = op_done_q;
  // Held balance only ever changes at commit or PIN acceptance, so it doubles as updated_balance.
  assign db.updated_balance = held;

  assign timer_en   = (state == PSW_WAIT) || (state == MENU);
  assign timer_load = !timer_en || psw_valid || op_valid;

  session_timer #(.timeout_cycles(timeout_cycles)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    sum  = {1'b0, held} + {1'b0, amt_r};
    diff = held - amt_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_r          <= OP_EXIT;
      card_q        <= 1'b0;
      tries         <= '0;
      held          <= '0;
      new_bal       <= '0;
      amt_r         <= '0;
      card_in_q     <= 1'b0;
      op_done_q     <= 1'b0;
      balance_disp  <= '0;
      op_error      <= 1'b0;
      card_eject    <= 1'b0;
      card_retained <= 1'b0;
    end else begin
      card_q        <= card_inserted;
      op_done_q     <= 1'b0;
      op_error      <= 1'b0;
      card_retained <= 1'b0;
      // Card removal aborts everything except an already-started commit.
      if (state != IDLE && !card_inserted) begin
        if (state == COMMIT) begin
          op_done_q    <= 1'b1;
          held         <= new_bal;
          balance_disp <= new_bal;
        end
        state      <= IDLE;
        card_in_q  <= 1'b0;
        card_eject <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (card_inserted && !card_q) begin
              state <= PSW_WAIT;
              tries <= '0;
            end
          end
          PSW_WAIT: begin
            if (psw_valid) begin
              state     <= CHECK_REQ;
              card_in_q <= 1'b1;
            end else if (timer_expired) begin
              state      <= EJECT;
              card_eject <= 1'b1;
            end
          end
          CHECK_REQ: state <= CHECK_WAIT;
          CHECK_WAIT: begin
            if (db.wrong_psw) begin
              card_in_q <= 1'b0;
              if (tries == TW'(max_tries - 1)) begin
                card_retained <= 1'b1;
                state         <= IDLE;
              end else begin
                tries <= tries + TW'(1);
                state <= PSW_WAIT;
              end
            end else begin
              held  <= db.balance;
              state <= MENU;
            end
          end
          MENU: begin
            if (op_valid) begin
              case (op_t'(op_sel))
                OP_INQUIRY: balance_disp <= held;
                OP_EXIT: begin
                  state      <= EJECT;
                  card_in_q  <= 1'b0;
                  card_eject <= 1'b1;
                end
                default: begin
                  op_r  <= op_t'(op_sel);
                  amt_r <= amount;
                  state <= EXEC;
                end
              endcase
            end else if (timer_expired) begin
              state      <= EJECT;
              card_in_q  <= 1'b0;
              card_eject <= 1'b1;
            end
          end
          EXEC: begin
            if (op_r == OP_WITHDRAW) begin
              if (amt_r > held) begin
                op_error <= 1'b1;
                state    <= MENU;
              end else begin
                new_bal <= diff;
                state   <= COMMIT;
              end
            end else if (sum[BW]) begin
              op_error <= 1'b1;
              state    <= MENU;
            end else begin
              new_bal <= sum[BW-1:0];
              state   <= COMMIT;
            end
          end
          COMMIT: begin
            op_done_q    <= 1'b1;
            held         <= new_bal;
            balance_disp <= new_bal;
            state        <= MENU;
          end
          EJECT: card_eject <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with hand-computed expectations.
module tb_atm_session_ctrl;
  localparam int unsigned BW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          card_inserted;
  logic          psw_valid;
  logic          op_valid;
  logic [1:0]    op_sel;
  logic [BW-1:0] amount;
  logic [BW-1:0] balance_disp;
  logic          op_error;
  logic          card_eject;
  logic          card_retained;

  int checks = 0;
  int errors = 0;

  atm_session_ctrl_if #(.balance_width(BW)) db ();

  atm_session_ctrl #(
    .balance_width  (BW),
    .max_tries      (3),
    .timeout_cycles (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .db            (db),
    .card_inserted (card_inserted),
    .psw_valid     (psw_valid),
    .op_valid      (op_valid),
    .op_sel        (op_sel),
    .amount        (amount),
    .balance_disp  (balance_disp),
    .op_error      (op_error),
    .card_eject    (card_eject),
    .card_retained (card_retained)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PIN entry: 3 ticks from psw_valid to the CHECK_WAIT decision being visible.
  task automatic pin(input logic wrong, input logic [BW-1:0] bal);
    psw_valid = 1'b1; db.wrong_psw = wrong; db.balance = bal;
    tick();
    psw_valid = 1'b0;
    chk("creq_card_in", {31'd0, db.card_in}, 32'd1);
    tick();
    tick();
  endtask

  task automatic start_op(input logic [1:0] sel, input logic [BW-1:0] amt);
    op_valid = 1'b1; op_sel = sel; amount = amt;
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; card_inserted = 1'b0; psw_valid = 1'b0; op_valid = 1'b0;
    op_sel = 2'b00; amount = '0; db.wrong_psw = 1'b0; db.balance = '0;
    tick(); tick();
    chk("rst_card_in", {31'd0, db.card_in}, 32'd0);
    chk("rst_op_done", {31'd0, db.op_done}, 32'd0);
    chk("rst_upd_bal", {12'd0, db.updated_balance}, 32'd0);
    chk("rst_disp", {12'd0, balance_disp}, 32'd0);
    chk("rst_flags", {29'd0, op_error, card_eject, card_retained}, 32'd0);
    rst = 1'b1;
    tick();

    // Session 1: PIN ok with 1000, inquiry, withdraw 300, 701, 700, exit.
    card_inserted = 1'b1; tick();
    chk("psw_wait_card_in", {31'd0, db.card_in}, 32'd0);
    pin(1'b0, 20'd1000);
    chk("menu_card_in", {31'd0, db.card_in}, 32'd1);
    chk("menu_held", {12'd0, db.updated_balance}, 32'd1000);
    chk("disp_before_inq", {12'd0, balance_disp}, 32'd0);
    start_op(2'b01, '0);
    chk("inquiry_disp", {12'd0, balance_disp}, 32'd1000);
    start_op(2'b10, 20'd300);
    chk("wd_exec_no_done", {31'd0, db.op_done}, 32'd0);
    tick();
    chk("wd_commit_no_done", {31'd0, db.op_done}, 32'd0);
    tick();
    chk("wd300_done", {31'd0, db.op_done}, 32'd1);
    chk("wd300_upd", {12'd0, db.updated_balance}, 32'd700);
    chk("wd300_disp", {12'd0, balance_disp}, 32'd700);
    tick();
    chk("wd300_done_pulse", {31'd0, db.op_done}, 32'd0);
    start_op(2'b10, 20'd701);
    tick();
    chk("wd701_err", {31'd0, op_error}, 32'd1);
    chk("wd701_no_done", {31'd0, db.op_done}, 32'd0);
    chk("wd701_menu", {31'd0, db.card_in}, 32'd1);
    tick();
    chk("wd701_err_pulse", {31'd0, op_error}, 32'd0);
    chk("wd701_no_done2", {31'd0, db.op_done}, 32'd0);
    chk("wd701_held", {12'd0, db.updated_balance}, 32'd700);
    start_op(2'b10, 20'd700);
    tick(); tick();
    chk("wd700_done", {31'd0, db.op_done}, 32'd1);
    chk("wd700_upd", {12'd0, db.updated_balance}, 32'd0);
    start_op(2'b00, '0);
    chk("exit_eject", {31'd0, card_eject}, 32'd1);
    chk("exit_card_in", {31'd0, db.card_in}, 32'd0);
    tick(); tick();
    chk("eject_hold", {31'd0, card_eject}, 32'd1);
    card_inserted = 1'b0; tick();
    chk("eject_release", {31'd0, card_eject}, 32'd0);

    // Session 2: deposit overflow at 0xFFFFF, then 0xFFFF0 + 5.
    card_inserted = 1'b1; tick();
    pin(1'b0, 20'hFFFFF);
    chk("ovf_held", {12'd0, db.updated_balance}, 32'hFFFFF);
    start_op(2'b11, 20'd1);
    chk("ovf_exec_no_done", {31'd0, db.op_done}, 32'd0);
    tick();
    chk("ovf_err", {31'd0, op_error}, 32'd1);
    chk("ovf_no_done", {31'd0, db.op_done}, 32'd0);
    tick();
    chk("ovf_no_done2", {31'd0, db.op_done}, 32'd0);
    chk("ovf_held_kept", {12'd0, db.updated_balance}, 32'hFFFFF);
    start_op(2'b10, 20'd15);
    tick(); tick();
    chk("wd15_upd", {12'd0, db.updated_balance}, 32'hFFFF0);
    start_op(2'b11, 20'd5);
    tick(); tick();
    chk("dep5_done", {31'd0, db.op_done}, 32'd1);
    chk("dep5_err", {31'd0, op_error}, 32'd0);
    chk("dep5_upd", {12'd0, db.updated_balance}, 32'hFFFF5);
    chk("dep5_disp", {12'd0, balance_disp}, 32'hFFFF5);

    // Pull card while in MENU, then three wrong PINs.
    card_inserted = 1'b0; tick();
    chk("pull_menu_card_in", {31'd0, db.card_in}, 32'd0);
    card_inserted = 1'b1; tick();
    pin(1'b1, '0);
    chk("wrong1_ret", {31'd0, card_retained}, 32'd0);
    chk("wrong1_card_in", {31'd0, db.card_in}, 32'd0);
    pin(1'b1, '0);
    chk("wrong2_ret", {31'd0, card_retained}, 32'd0);
    pin(1'b1, '0);
    chk("wrong3_ret", {31'd0, card_retained}, 32'd1);
    tick();
    chk("wrong3_ret_pulse", {31'd0, card_retained}, 32'd0);
    psw_valid = 1'b1; tick(); psw_valid = 1'b0;
    chk("idle_psw_ignored", {31'd0, db.card_in}, 32'd0);

    // Two wrong then right; then MENU inactivity timeout.
    card_inserted = 1'b0; tick();
    card_inserted = 1'b1; tick();
    pin(1'b1, '0);
    pin(1'b1, '0);
    pin(1'b0, 20'd50);
    chk("retry_menu", {31'd0, db.card_in}, 32'd1);
    chk("retry_held", {12'd0, db.updated_balance}, 32'd50);
    repeat (255) tick();
    chk("timeout_not_yet", {31'd0, card_eject}, 32'd0);
    tick();
    chk("timeout_eject", {31'd0, card_eject}, 32'd1);
    chk("timeout_card_in", {31'd0, db.card_in}, 32'd0);
    repeat (3) tick();
    chk("timeout_eject_hold", {31'd0, card_eject}, 32'd1);
    card_inserted = 1'b0; tick();
    chk("timeout_release", {31'd0, card_eject}, 32'd0);

    // Card pulled in EXEC: no commit.
    card_inserted = 1'b1; tick();
    pin(1'b0, 20'd1000);
    start_op(2'b10, 20'd100);
    card_inserted = 1'b0; tick();
    chk("pull_exec_done", {31'd0, db.op_done}, 32'd0);
    chk("pull_exec_card_in", {31'd0, db.card_in}, 32'd0);
    tick();
    chk("pull_exec_done2", {31'd0, db.op_done}, 32'd0);
    chk("pull_exec_held", {12'd0, db.updated_balance}, 32'd1000);

    // Card pulled in COMMIT: commit still happens.
    card_inserted = 1'b1; tick();
    pin(1'b0, 20'd1000);
    start_op(2'b10, 20'd100);
    tick();
    card_inserted = 1'b0; tick();
    chk("pull_commit_done", {31'd0, db.op_done}, 32'd1);
    chk("pull_commit_upd", {12'd0, db.updated_balance}, 32'd900);
    chk("pull_commit_card_in", {31'd0, db.card_in}, 32'd0);

    // Async reset mid-EXEC.
    card_inserted = 1'b1; tick();
    pin(1'b0, 20'd1000);
    start_op(2'b11, 20'd10);
    rst = 1'b0; #1;
    chk("rst_exec_card_in", {31'd0, db.card_in}, 32'd0);
    chk("rst_exec_upd", {12'd0, db.updated_balance}, 32'd0);
    chk("rst_exec_disp", {12'd0, balance_disp}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_exec_no_done1", {31'd0, db.op_done}, 32'd0);
    tick();
    chk("rst_exec_no_done2", {31'd0, db.op_done}, 32'd0);
    tick();
    chk("rst_exec_no_done3", {31'd0, db.op_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
